// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the sized data memory controller.
// Access-size codes, controller state type, and byte-mask functions sized for up to 8 lanes.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // Byte-lane mask for an access of 2^sz bytes, before shifting to the offset.
    function automatic logic [7:0] size_be(input logic [1:0] sz);
        return 8'((16'd1 << (4'd1 << sz)) - 16'd1);
    endfunction

    // Low address bits that must be zero for an access of 2^sz bytes.
    function automatic logic [7:0] align_mask(input logic [1:0] sz);
        return 8'((4'd1 << sz) - 4'd1);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and data, load extract and extend, misalign flag.
// Zero latency; no handshake.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter  int XLEN  = 64,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       i_size,
    input  logic [OFF_W-1:0] i_offset,
    input  logic             i_unsigned,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rword,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_rdata,
    output logic             o_misalign
);

    logic [NB-1:0]   w_lanes;
    logic [XLEN-1:0] w_shifted;
    logic            w_fill;

    assign w_lanes    = NB'(size_be(i_size));
    assign o_be       = w_lanes << i_offset;
    assign o_wdata    = i_wdata << {i_offset, 3'b000};
    assign w_shifted  = i_rword >> {i_offset, 3'b000};
    assign o_misalign = ((i_size == SZ_D) && (XLEN < 64)) ||
                        ((i_offset & OFF_W'(align_mask(i_size))) != '0);

    // Sign bit is the top bit of the highest enabled lane; full-width loads never extend.
    always_comb begin
        w_fill  = 1'b0;
        o_rdata = '0;
        for (int i = 0; i < NB; i++) begin
            if (w_lanes[i]) w_fill = w_shifted[8*i+7];
        end
        if (i_unsigned || (&w_lanes)) w_fill = 1'b0;
        for (int i = 0; i < NB; i++) begin
            o_rdata[8*i +: 8] = w_lanes[i] ? w_shifted[8*i +: 8] : {8{w_fill}};
        end
    end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// Sized load/store data memory with one access outstanding; response RD_LATENCY cycles after accept,
// held until rsp_ready, no new accept meanwhile. DMEM_PERF_EN adds access counters.
module dmem_sized_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 64,
    parameter int RD_LATENCY = 1,
    parameter int INIT_WORDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 2;

    if (RD_LATENCY < 1 || RD_LATENCY > 4 || INIT_WORDS > DEPTH) begin : g_bad_param
        $error("dmem_sized_ctrl: RD_LATENCY must be 1..4 and INIT_WORDS <= DEPTH");
    end

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [XLEN-1:0]  r_pend_rdata, r_rsp_rdata;
    logic             r_pend_err, r_rsp_err;

    logic             w_accept, w_oor, w_misalign, w_err;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic [NB-1:0]    w_be;
    logic [XLEN-1:0]  w_wdata_al, w_ld_data, w_rword, w_result;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_accept = req_valid & req_ready;
    assign w_idx    = req_addr[OFF_W +: IDX_W];
    assign w_off    = req_addr[OFF_W-1:0];
    assign w_oor    = (req_addr >> OFF_W) >= ADDR_W'(DEPTH);
    assign w_err    = w_oor | w_misalign;
    assign w_rword  = r_mem[w_idx];
    assign w_result = (req_we || w_err) ? '0 : w_ld_data;

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .i_size     (req_size),
        .i_offset   (w_off),
        .i_unsigned (req_unsigned),
        .i_wdata    (req_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_wdata_al),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (RD_LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The load result is computed at accept; it reaches rsp_rdata directly or via the pending copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_pend_rdata <= '0;
            r_pend_err   <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_pend_rdata <= w_result;
                r_pend_err   <= w_err;
            end
            if ((w_state_nxt == RESP) && (r_state != RESP)) begin
                r_rsp_rdata <= (r_state == IDLE) ? w_result : r_pend_rdata;
                r_rsp_err   <= (r_state == IDLE) ? w_err    : r_pend_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_err) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_al[8*i +: 8];
            end
        end
    end

`ifdef DMEM_PERF_EN
    logic [31:0] r_perf_loads, r_perf_stores, r_perf_errs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_loads  <= '0;
            r_perf_stores <= '0;
            r_perf_errs   <= '0;
        end else if (w_accept) begin
            if (w_err)       r_perf_errs   <= r_perf_errs + 32'd1;
            else if (req_we) r_perf_stores <= r_perf_stores + 32'd1;
            else             r_perf_loads  <= r_perf_loads + 32'd1;
        end
    end

    assign perf_loads  = r_perf_loads;
    assign perf_stores = r_perf_stores;
    assign perf_errs   = r_perf_errs;
`else
    // Counter-free build: no access statistics are kept.
`endif

endmodule
